// File: rtl/stall_ctrl.sv
// Pipeline stall controller: register-dependency and HI/LO hazard detection,
// multiply/divide busy tracking and a saturating stalled-cycle counter.
module stall_ctrl #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  Tuse_rs_D,
   input  logic [1:0]  Tuse_rt_D,
   input  logic [4:0]  A3_E,
   input  logic [4:0]  A3_M,
   input  logic [3:0]  Tnew_E,
   input  logic [3:0]  Tnew_M,
   input  logic        md_start_E,
   input  logic        md_div_E,
   input  logic        md_use_D,
   input  logic        stall_cnt_clr,
   output logic        en_F,
   output logic        en_D,
   output logic        clr_E,
   output logic        md_busy,
   output logic [3:0]  md_cnt,
   output logic [15:0] stall_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   md_state_t   state_r;
   logic        md_busy_r;
   logic [3:0]  md_cnt_r;
   logic [15:0] stall_cnt_r;

   logic        hz_rs_s;
   logic        hz_rt_s;
   logic        hz_md_s;
   logic        stall_s;

   // A source register is hazardous if a younger-stage producer is not ready in time.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] a3_e,
      input logic [3:0] tnew_e,
      input logic [4:0] a3_m,
      input logic [3:0] tnew_m
   );
      logic hit_e;
      logic hit_m;
      hit_e = (src == a3_e) && (tnew_e > {2'b00, tuse});
      hit_m = (src == a3_m) && (tnew_m > {2'b00, tuse});
      return (src != 5'd0) && (hit_e || hit_m);
   endfunction

   // Hazard detection and pipeline enables; a flush request always wins over a stall.
   always_comb begin
      hz_rs_s = src_hazard(rs_D, Tuse_rs_D, A3_E, Tnew_E, A3_M, Tnew_M);
      hz_rt_s = src_hazard(rt_D, Tuse_rt_D, A3_E, Tnew_E, A3_M, Tnew_M);
      hz_md_s = md_use_D && (md_busy_r || md_start_E);
      if (Req) begin
         stall_s = 1'b0;
      end else begin
         stall_s = hz_rs_s || hz_rt_s || hz_md_s;
      end
      en_F  = ~stall_s;
      en_D  = ~stall_s;
      clr_E = stall_s;
   end

   // Multiply/divide occupancy FSM; a started operation runs to completion regardless of Req.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         md_busy_r <= 1'b0;
         md_cnt_r  <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (md_start_E && !Req) begin
                  state_r   <= BUSY;
                  md_busy_r <= 1'b1;
                  md_cnt_r  <= md_div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
               end else begin
                  state_r   <= IDLE;
                  md_busy_r <= 1'b0;
                  md_cnt_r  <= 4'd0;
               end
            end
            BUSY: begin
               if (md_cnt_r <= 4'd1) begin
                  state_r   <= IDLE;
                  md_busy_r <= 1'b0;
                  md_cnt_r  <= 4'd0;
               end else begin
                  state_r   <= BUSY;
                  md_busy_r <= 1'b1;
                  md_cnt_r  <= md_cnt_r - 4'd1;
               end
            end
            default: begin
               state_r   <= IDLE;
               md_busy_r <= 1'b0;
               md_cnt_r  <= 4'd0;
            end
         endcase
      end
   end

   // Saturating stalled-cycle counter; clear beats increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= 16'd0;
      end else if (stall_cnt_clr) begin
         stall_cnt_r <= 16'd0;
      end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign md_busy   = md_busy_r;
   assign md_cnt    = md_cnt_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl with hand-computed expectations.
module tb_stall_ctrl;

   logic        clk;
   logic        reset;
   logic        Req;
   logic [4:0]  rs_D;
   logic [4:0]  rt_D;
   logic [1:0]  Tuse_rs_D;
   logic [1:0]  Tuse_rt_D;
   logic [4:0]  A3_E;
   logic [4:0]  A3_M;
   logic [3:0]  Tnew_E;
   logic [3:0]  Tnew_M;
   logic        md_start_E;
   logic        md_div_E;
   logic        md_use_D;
   logic        stall_cnt_clr;
   logic        en_F;
   logic        en_D;
   logic        clr_E;
   logic        md_busy;
   logic [3:0]  md_cnt;
   logic [15:0] stall_cnt;

   int total;
   int bad;

   stall_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .Req           (Req),
      .rs_D          (rs_D),
      .rt_D          (rt_D),
      .Tuse_rs_D     (Tuse_rs_D),
      .Tuse_rt_D     (Tuse_rt_D),
      .A3_E          (A3_E),
      .A3_M          (A3_M),
      .Tnew_E        (Tnew_E),
      .Tnew_M        (Tnew_M),
      .md_start_E    (md_start_E),
      .md_div_E      (md_div_E),
      .md_use_D      (md_use_D),
      .stall_cnt_clr (stall_cnt_clr),
      .en_F          (en_F),
      .en_D          (en_D),
      .clr_E         (clr_E),
      .md_busy       (md_busy),
      .md_cnt        (md_cnt),
      .stall_cnt     (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ins();
      Req = 1'b0; rs_D = 5'd0; rt_D = 5'd0; Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3;
      A3_E = 5'd0; A3_M = 5'd0; Tnew_E = 4'd0; Tnew_M = 4'd0;
      md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0; stall_cnt_clr = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      int guard;
      total = 0;
      bad   = 0;
      reset = 1'b0;
      clear_ins();
      #2;
      chk("rst_busy", {31'd0, md_busy}, 32'd0);
      chk("rst_cnt", {28'd0, md_cnt}, 32'd0);
      chk("rst_scnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_enF", {31'd0, en_F}, 32'd1);
      // combinational path still live during reset
      rs_D = 5'd5; Tuse_rs_D = 2'd0; A3_E = 5'd5; Tnew_E = 4'd2;
      #1;
      chk("rst_hz_clrE", {31'd0, clr_E}, 32'd1);
      clear_ins();
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("first_busy", {31'd0, md_busy}, 32'd0);
      chk("first_scnt", {16'd0, stall_cnt}, 32'd0);

      // load-use on rs via E then M
      rs_D = 5'd5; Tuse_rs_D = 2'd0; A3_E = 5'd5; Tnew_E = 4'd2;
      #1;
      chk("lu_enF", {31'd0, en_F}, 32'd0);
      chk("lu_enD", {31'd0, en_D}, 32'd0);
      chk("lu_clrE", {31'd0, clr_E}, 32'd1);
      tick();
      A3_E = 5'd0; Tnew_E = 4'd0; A3_M = 5'd5; Tnew_M = 4'd1;
      #1;
      chk("lu_m_clrE", {31'd0, clr_E}, 32'd1);
      chk("lu_scnt1", {16'd0, stall_cnt}, 32'd1);
      tick();
      Tnew_M = 4'd0;
      #1;
      chk("lu_rel_enF", {31'd0, en_F}, 32'd1);
      chk("lu_rel_clrE", {31'd0, clr_E}, 32'd0);
      tick();
      chk("lu_scnt2", {16'd0, stall_cnt}, 32'd2);

      // rt hazard, and an unused operand never stalls
      clear_ins();
      rt_D = 5'd7; Tuse_rt_D = 2'd1; A3_M = 5'd7; Tnew_M = 4'd2;
      #1;
      chk("rt_clrE", {31'd0, clr_E}, 32'd1);
      Tuse_rt_D = 2'd3;
      #1;
      chk("rt_unused", {31'd0, clr_E}, 32'd0);
      clear_ins();

      // mult followed by HI/LO reader
      md_start_E = 1'b1; md_div_E = 1'b0; md_use_D = 1'b1;
      #1;
      chk("mul_c0_clrE", {31'd0, clr_E}, 32'd1);
      tick();
      md_start_E = 1'b0;
      for (int k = 5; k >= 1; k--) begin
         #1;
         chk("mul_cnt", {28'd0, md_cnt}, k);
         chk("mul_busy", {31'd0, md_busy}, 32'd1);
         chk("mul_clrE", {31'd0, clr_E}, 32'd1);
         tick();
      end
      chk("mul_end_cnt", {28'd0, md_cnt}, 32'd0);
      chk("mul_end_busy", {31'd0, md_busy}, 32'd0);
      chk("mul_end_enF", {31'd0, en_F}, 32'd1);
      chk("mul_scnt", {16'd0, stall_cnt}, 32'd8);
      md_use_D = 1'b0;

      // div occupancy length
      md_start_E = 1'b1; md_div_E = 1'b1;
      tick();
      md_start_E = 1'b0; md_div_E = 1'b0;
      chk("div_cnt10", {28'd0, md_cnt}, 32'd10);
      busy_cycles = 0;
      guard = 0;
      while (md_busy && guard < 20) begin
         busy_cycles++;
         guard++;
         tick();
      end
      chk("div_busy_len", busy_cycles, 32'd10);

      // flush squashes the start and overrides the stall
      Req = 1'b1; md_start_E = 1'b1; md_use_D = 1'b1;
      rs_D = 5'd5; Tuse_rs_D = 2'd0; A3_E = 5'd5; Tnew_E = 4'd2;
      #1;
      chk("req_clrE", {31'd0, clr_E}, 32'd0);
      chk("req_enF", {31'd0, en_F}, 32'd1);
      tick();
      chk("req_nostart", {31'd0, md_busy}, 32'd0);
      chk("req_scnt", {16'd0, stall_cnt}, 32'd8);
      clear_ins();

      // flush during BUSY leaves the count alone
      md_start_E = 1'b1;
      tick();
      md_start_E = 1'b0;
      tick();
      chk("reqb_cnt4", {28'd0, md_cnt}, 32'd4);
      Req = 1'b1;
      for (int k = 3; k >= 0; k--) begin
         tick();
         chk("reqb_cnt", {28'd0, md_cnt}, k);
      end
      clear_ins();

      // saturation and clear priority
      stall_cnt_clr = 1'b1;
      tick();
      chk("sc_clr", {16'd0, stall_cnt}, 32'd0);
      stall_cnt_clr = 1'b0;
      rs_D = 5'd5; Tuse_rs_D = 2'd0; A3_E = 5'd5; Tnew_E = 4'd2;
      for (int i = 0; i < 65534; i++) tick();
      chk("sc_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
      tick();
      chk("sc_ffff1", {16'd0, stall_cnt}, 32'h0000FFFF);
      tick();
      tick();
      chk("sc_ffff3", {16'd0, stall_cnt}, 32'h0000FFFF);
      stall_cnt_clr = 1'b1;
      tick();
      chk("sc_clr_prio", {16'd0, stall_cnt}, 32'd0);
      clear_ins();

      // async reset mid-division
      md_start_E = 1'b1; md_div_E = 1'b1;
      tick();
      md_start_E = 1'b0; md_div_E = 1'b0;
      tick(); tick(); tick();
      chk("ar_cnt7", {28'd0, md_cnt}, 32'd7);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_busy", {31'd0, md_busy}, 32'd0);
      chk("ar_cnt", {28'd0, md_cnt}, 32'd0);
      rs_D = 5'd0; A3_E = 5'd0; Tnew_E = 4'd3; Tuse_rs_D = 2'd0;
      #1;
      chk("zero_reg", {31'd0, clr_E}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("post_rst_busy", {31'd0, md_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
